// File: rtl/mult_host_pkg.sv
// mult_host_pkg: shared types and defaults for the multiplier host requester.
//   mult_host_state_t      : requester FSM state encoding
//   DEFAULT_WORD_LENGTH    : default operand width (product is twice this)
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit in clock cycles
//   TIMEOUT_CW             : watchdog counter width for the default limit
package mult_host_pkg;

  localparam int DEFAULT_WORD_LENGTH    = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int TIMEOUT_CW             = $clog2(DEFAULT_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } mult_host_state_t;

endpackage

// File: rtl/mult_watchdog.sv
// mult_watchdog: cycle counter that flags a stalled multiplier transaction.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous active-low reset (count -> 0)
//   clear   : restart the count at zero
//   enable  : count this cycle (host is waiting on the multiplier)
//   expired : enable is high and TIMEOUT_CYCLES waiting cycles have elapsed,
//             i.e. this is the last permitted waiting cycle
module mult_watchdog
  import mult_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at LIMIT so a held enable never wraps back to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/mult_host_if.sv
// mult_host_if: host-side requester for the sequential multiplier.
// Accepts one operand pair at a time, pulses mult_start, follows the
// multiplier's mult_ready high->low->high sequence and returns the product.
// Optional feature: define MULT_HOST_TIMEOUT_EN to add a watchdog that aborts
// a stalled transaction with rsp_error=1 and rsp_product=0.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The requester keeps valid and its payload steady until that
// edge. req_ready is a pure state decode; rsp_valid is registered, so there
// is no same-cycle path from rsp_ready to req_ready.
//
// Ports:
//   clk, reset                  : clock, synchronous active-low reset
//   req_valid/req_ready/req_a/b : operand request port
//   mult_start                  : one-cycle start pulse to the multiplier
//   mult_multiplicand/multiplier: operands latched at acceptance
//   mult_ready, mult_product    : multiplier idle/done flag and result
//   rsp_valid/rsp_ready         : response port
//   rsp_product, rsp_error      : captured product, timeout-abort flag
//   dbg_state                   : current FSM state
module mult_host_if
  import mult_host_pkg::*;
#(
  parameter int WORD_LENGTH    = DEFAULT_WORD_LENGTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WORD_LENGTH-1:0]   req_a,
  input  logic [WORD_LENGTH-1:0]   req_b,
  output logic                     mult_start,
  output logic [WORD_LENGTH-1:0]   mult_multiplicand,
  output logic [WORD_LENGTH-1:0]   mult_multiplier,
  input  logic                     mult_ready,
  input  logic [2*WORD_LENGTH-1:0] mult_product,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*WORD_LENGTH-1:0] rsp_product,
  output logic                     rsp_error,
  output mult_host_state_t         dbg_state
);

  mult_host_state_t state, next_state;
  logic             wd_expired;
  logic             accept;
  logic             capture_done;
  logic             capture_abort;

`ifdef MULT_HOST_TIMEOUT_EN
  mult_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == LAUNCH),
    .enable ((state == WAIT_BUSY) || (state == WAIT_DONE)),
    .expired(wd_expired)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
  assign wd_expired            = 1'b0;
`endif

  assign req_ready    = (state == IDLE);
  assign accept       = req_valid && req_ready;
  assign capture_done = (state == WAIT_DONE) && mult_ready;
  // A genuine exit on the limit edge takes priority over the abort.
  assign capture_abort = wd_expired &&
                         (((state == WAIT_BUSY) && mult_ready) ||
                          ((state == WAIT_DONE) && !mult_ready));
  assign dbg_state     = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = LAUNCH;
      LAUNCH:    next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!mult_ready)        next_state = WAIT_DONE;
        else if (capture_abort) next_state = RESPOND;
      end
      WAIT_DONE: begin
        if (capture_done || capture_abort) next_state = RESPOND;
      end
      RESPOND:   if (rsp_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      mult_start        <= 1'b0;
      mult_multiplicand <= '0;
      mult_multiplier   <= '0;
      rsp_valid         <= 1'b0;
      rsp_product       <= '0;
      rsp_error         <= 1'b0;
    end else begin
      state      <= next_state;
      mult_start <= (next_state == LAUNCH);
      rsp_valid  <= (next_state == RESPOND);
      if (accept) begin
        mult_multiplicand <= req_a;
        mult_multiplier   <= req_b;
      end
      if (capture_done) begin
        rsp_product <= mult_product;
        rsp_error   <= 1'b0;
      end else if (capture_abort) begin
        rsp_product <= '0;
        rsp_error   <= 1'b1;
      end
    end
  end

endmodule
